network_sim_ctrl: RTL and testbench

Sequencer for the synchronous Boolean-network update block (`network_logic`). It loads an initial network state and applies a per-run knockout/force mask to every state. It steps the network one synchronous update at a time and streams each state, tagged with its step number, to a capture host over a valid/ready handshake. A run ends on a fixed point, a step limit or an abort, and the block reports which one occurred.

---
 rtl/network_sim_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_network_sim_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_sim_ctrl.sv
// network_sim_ctrl
// ----------------
// Sequencer for a synchronous Boolean-network update block (network_logic).
// A run loads an initial state, applies a knockout/force mask to every state,
// steps the network one update at a time, and streams each state tagged with
// its step number to a capture host. A run ends on a fixed point, a step
// limit or an abort, and the block reports which one ended it.
//
// Parameters
//   STATE_W      width of the network state vector
//   STEP_W       width of the step counter and step limit
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  run request
//   start_ready  high only while idle; run accepted on start_valid & start_ready
//   init_state   initial network state, sampled on accept
//   force_mask   1 = element forced, sampled on accept
//   force_val    value of each forced element, sampled on accept
//   max_steps    step limit, sampled on accept
//   abort        cancels an active run
//   logic_cur    current state presented to the update block
//   logic_nxt    registered next state from the update block
//   out_valid    state record available
//   out_ready    host accepts the record
//   out_state    state record
//   out_step     step index of out_state (initial state is step 0)
//   done         level, run finished; held until the next accepted start
//   done_reason  01 fixed point, 10 step limit, 11 aborted, 00 none

`ifndef STATE
`define STATE 8
`endif

module network_sim_ctrl #(
  parameter int STATE_W = `STATE,
  parameter int STEP_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [STATE_W-1:0] init_state,
  input  logic [STATE_W-1:0] force_mask,
  input  logic [STATE_W-1:0] force_val,
  input  logic [STEP_W-1:0]  max_steps,
  input  logic               abort,
  output logic [STATE_W-1:0] logic_cur,
  input  logic [STATE_W-1:0] logic_nxt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic [STEP_W-1:0]  out_step,
  output logic               done,
  output logic [1:0]         done_reason
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_EVAL,
    S_SAMPLE,
    S_DONE
  } fsm_t;

  localparam logic [1:0] REASON_NONE  = 2'b00;
  localparam logic [1:0] REASON_FIXED = 2'b01;
  localparam logic [1:0] REASON_LIMIT = 2'b10;
  localparam logic [1:0] REASON_ABORT = 2'b11;

  fsm_t               fsm;
  logic [STATE_W-1:0] net_state;
  logic [STATE_W-1:0] mask_q;
  logic [STATE_W-1:0] val_q;
  logic [STEP_W-1:0]  step_q;
  logic [STEP_W-1:0]  limit_q;
  logic               fixed_q;
  logic               done_q;
  logic [1:0]         reason_q;

  logic [STATE_W-1:0] init_forced;
  logic [STATE_W-1:0] next_forced;
  logic               accept;
  logic               handshake;

  // Forced elements take their latched value; the rest pass through.
  function automatic logic [STATE_W-1:0] apply_force(
    input logic [STATE_W-1:0] x,
    input logic [STATE_W-1:0] m,
    input logic [STATE_W-1:0] v
  );
    return (x & ~m) | (v & m);
  endfunction

  // The initial state is forced with the mask arriving alongside it, since
  // the latched copies only become valid after the accept edge.
  assign init_forced = apply_force(init_state, force_mask, force_val);
  assign next_forced = apply_force(logic_nxt, mask_q, val_q);

  assign accept    = start_valid && (fsm == S_IDLE);
  assign handshake = out_ready && (fsm == S_EMIT);

  // All outputs come straight from registers or the FSM state, so no input
  // has a combinational path to an output.
  assign start_ready = (fsm == S_IDLE);
  assign out_valid   = (fsm == S_EMIT);
  assign out_state   = net_state;
  assign out_step    = step_q;
  assign logic_cur   = net_state;
  assign done        = done_q;
  assign done_reason = reason_q;

  // Sequencer: one record per step, then evaluate and sample the update
  // block. Abort outranks everything in the active states, including a
  // handshake in the same cycle, so a pending record is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      net_state <= '0;
      mask_q    <= '0;
      val_q     <= '0;
      step_q    <= '0;
      limit_q   <= '0;
      fixed_q   <= 1'b0;
      done_q    <= 1'b0;
      reason_q  <= REASON_NONE;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (accept) begin
            net_state <= init_forced;
            mask_q    <= force_mask;
            val_q     <= force_val;
            limit_q   <= max_steps;
            step_q    <= '0;
            fixed_q   <= 1'b0;
            done_q    <= 1'b0;
            reason_q  <= REASON_NONE;
            fsm       <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (abort) begin
            done_q   <= 1'b1;
            reason_q <= REASON_ABORT;
            fsm      <= S_DONE;
          end else if (handshake) begin
            // A fixed point wins over the limit when both hold at once.
            if (fixed_q) begin
              done_q   <= 1'b1;
              reason_q <= REASON_FIXED;
              fsm      <= S_DONE;
            end else if (step_q == limit_q) begin
              done_q   <= 1'b1;
              reason_q <= REASON_LIMIT;
              fsm      <= S_DONE;
            end else begin
              fsm <= S_EVAL;
            end
          end
        end

        S_EVAL: begin
          if (abort) begin
            done_q   <= 1'b1;
            reason_q <= REASON_ABORT;
            fsm      <= S_DONE;
          end else begin
            fsm <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          if (abort) begin
            done_q   <= 1'b1;
            reason_q <= REASON_ABORT;
            fsm      <= S_DONE;
          end else begin
            // Full-vector compare, forced elements included.
            fixed_q   <= (next_forced == net_state);
            net_state <= next_forced;
            step_q    <= step_q + STEP_W'(1);
            fsm       <= S_EMIT;
          end
        end

        S_DONE: begin
          fsm <= S_IDLE;
        end

        default: begin
          fsm <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_network_sim_ctrl.sv
// tb_network_sim_ctrl
// -------------------
// Directed bench for network_sim_ctrl with an 8-bit state. A small model of
// the update block is either a registered +1 counter or a registered
// identity, selected per scenario. Expected records are hand-computed.

module tb_network_sim_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  init_state;
  logic [7:0]  force_mask;
  logic [7:0]  force_val;
  logic [15:0] max_steps;
  logic        abort;
  logic [7:0]  logic_cur;
  logic [7:0]  logic_nxt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_state;
  logic [15:0] out_step;
  logic        done;
  logic [1:0]  done_reason;

  int checks;
  int errors;
  int blk_mode;

  logic [7:0]  rec_state[$];
  logic [15:0] rec_step[$];
  int          last_hs;
  bit          got_done;

  network_sim_ctrl #(
    .STATE_W(8),
    .STEP_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .init_state (init_state),
    .force_mask (force_mask),
    .force_val  (force_val),
    .max_steps  (max_steps),
    .abort      (abort),
    .logic_cur  (logic_cur),
    .logic_nxt  (logic_nxt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_step   (out_step),
    .done       (done),
    .done_reason(done_reason)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Update block model: registered, one clock of latency.
  always @(posedge clk) begin
    if (blk_mode == 1) logic_nxt <= logic_cur;
    else               logic_nxt <= logic_cur + 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] init, input logic [7:0] m,
                           input logic [7:0] v, input logic [15:0] lim);
    int n;
    n = 0;
    while (start_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_wait start_ready=%b required=1", start_ready);
    end
    init_state  = init;
    force_mask  = m;
    force_val   = v;
    max_steps   = lim;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_valid out_valid=%b required=1", out_valid);
    end
  endtask

  // Records every handshake until done rises or the budget expires.
  // last_hs is the edge count from accept to the latest handshake.
  task automatic collect(input int budget);
    rec_state.delete();
    rec_step.delete();
    last_hs  = -1;
    got_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        rec_state.push_back(out_state);
        rec_step.push_back(out_step);
        last_hs = i + 1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (start_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_start_ready actual=%b required=1", start_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid actual=%b required=0", out_valid); end
    checks++;
    if (done !== 1'b0 || done_reason !== 2'b00) begin
      errors++; $display("[TB] FAIL rst_done actual=%b/%b required=0/00", done, done_reason);
    end
    checks++;
    if (logic_cur !== 8'h00 || out_state !== 8'h00 || out_step !== 16'd0) begin
      errors++; $display("[TB] FAIL rst_data actual=%h/%h/%0d required=00/00/0", logic_cur, out_state, out_step);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_counter();
    blk_mode  = 0;
    out_ready = 1'b1;
    start_run(8'h00, 8'h00, 8'h00, 16'd3);
    collect(100);
    checks++;
    if (!got_done) begin errors++; $display("[TB] FAIL cnt_timeout done=%b required=1", done); end
    checks++;
    if (rec_state.size() != 4) begin errors++; $display("[TB] FAIL cnt_count actual=%0d required=4", rec_state.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rec_state.size()) begin
        errors++; $display("[TB] FAIL cnt_rec%0d missing required=(%0d,%h)", i, i, i);
      end else if (rec_step[i] !== 16'(i) || rec_state[i] !== 8'(i)) begin
        errors++; $display("[TB] FAIL cnt_rec%0d actual=(%0d,%h) required=(%0d,%h)", i, rec_step[i], rec_state[i], i, i);
      end
    end
    checks++;
    if (done_reason !== 2'b10) begin errors++; $display("[TB] FAIL cnt_reason actual=%b required=10", done_reason); end
    checks++;
    if (last_hs != 10) begin errors++; $display("[TB] FAIL cnt_latency actual=%0d required=10", last_hs); end
    checks++;
    if (start_ready !== 1'b0) begin errors++; $display("[TB] FAIL cnt_done_busy start_ready=%b required=0", start_ready); end
    tick();
    checks++;
    if (start_ready !== 1'b1 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL cnt_idle start_ready/done=%b/%b required=1/1", start_ready, done);
    end
  endtask

  task automatic test_fixed_point();
    blk_mode  = 1;
    out_ready = 1'b1;
    start_run(8'hA5, 8'h00, 8'h00, 16'd10);
    collect(100);
    checks++;
    if (!got_done) begin errors++; $display("[TB] FAIL fix_timeout done=%b required=1", done); end
    checks++;
    if (rec_state.size() != 2) begin
      errors++; $display("[TB] FAIL fix_count actual=%0d required=2", rec_state.size());
    end else if (rec_step[0] !== 16'd0 || rec_state[0] !== 8'hA5 || rec_step[1] !== 16'd1 || rec_state[1] !== 8'hA5) begin
      errors++; $display("[TB] FAIL fix_recs actual=(%0d,%h)(%0d,%h) required=(0,a5)(1,a5)",
                         rec_step[0], rec_state[0], rec_step[1], rec_state[1]);
    end
    checks++;
    if (done_reason !== 2'b01) begin errors++; $display("[TB] FAIL fix_reason actual=%b required=01", done_reason); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fix_no_more cycle %0d out_valid=%b required=0", i, out_valid); end
      tick();
    end
    blk_mode = 0;
  endtask

  task automatic test_forced();
    logic [7:0] exp_s [3];
    exp_s[0] = 8'h01;
    exp_s[1] = 8'h03;
    exp_s[2] = 8'h05;
    blk_mode  = 0;
    out_ready = 1'b1;
    start_run(8'h00, 8'h01, 8'h01, 16'd2);
    collect(100);
    checks++;
    if (rec_state.size() != 3) begin errors++; $display("[TB] FAIL frc_count actual=%0d required=3", rec_state.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rec_state.size()) begin
        errors++; $display("[TB] FAIL frc_rec%0d missing required=%h", i, exp_s[i]);
      end else if (rec_state[i] !== exp_s[i] || rec_step[i] !== 16'(i) || rec_state[i][0] !== 1'b1) begin
        errors++; $display("[TB] FAIL frc_rec%0d actual=(%0d,%h) required=(%0d,%h)", i, rec_step[i], rec_state[i], i, exp_s[i]);
      end
    end
    checks++;
    if (done_reason !== 2'b10) begin errors++; $display("[TB] FAIL frc_reason actual=%b required=10", done_reason); end
  endtask

  task automatic test_stall();
    logic [7:0]  held_s;
    logic [15:0] held_n;
    bit          stalled;
    bit          fin;
    stalled  = 1'b0;
    fin      = 1'b0;
    blk_mode = 0;
    rec_state.delete();
    rec_step.delete();
    out_ready = 1'b0;
    start_run(8'h20, 8'h00, 8'h00, 16'd2);
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        fin = 1'b1;
        break;
      end
      out_ready = i[0];
      if (out_valid === 1'b1 && stalled) begin
        checks++;
        if (out_state !== held_s || out_step !== held_n) begin
          errors++; $display("[TB] FAIL stl_stable actual=(%0d,%h) required=(%0d,%h)", out_step, out_state, held_n, held_s);
        end
      end
      stalled = (out_valid === 1'b1 && out_ready === 1'b0);
      held_s  = out_state;
      held_n  = out_step;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        rec_state.push_back(out_state);
        rec_step.push_back(out_step);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (!fin) begin errors++; $display("[TB] FAIL stl_timeout done=%b required=1", done); end
    checks++;
    if (rec_state.size() != 3) begin
      errors++; $display("[TB] FAIL stl_count actual=%0d required=3", rec_state.size());
    end else if (rec_state[0] !== 8'h20 || rec_state[1] !== 8'h21 || rec_state[2] !== 8'h22 ||
                 rec_step[0] !== 16'd0 || rec_step[1] !== 16'd1 || rec_step[2] !== 16'd2) begin
      errors++; $display("[TB] FAIL stl_recs actual=%h,%h,%h required=20,21,22", rec_state[0], rec_state[1], rec_state[2]);
    end
    checks++;
    if (done_reason !== 2'b10) begin errors++; $display("[TB] FAIL stl_reason actual=%b required=10", done_reason); end
  endtask

  task automatic test_abort();
    bit aborted;
    aborted  = 1'b0;
    blk_mode = 0;
    rec_state.delete();
    rec_step.delete();
    out_ready = 1'b1;
    start_run(8'h00, 8'h00, 8'h00, 16'd100);
    for (int i = 0; i < 200; i++) begin
      if (out_valid === 1'b1 && out_step === 16'd5) begin
        out_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b1;
        aborted   = 1'b1;
        break;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        rec_state.push_back(out_state);
        rec_step.push_back(out_step);
      end
      tick();
    end
    checks++;
    if (!aborted) begin errors++; $display("[TB] FAIL abt_timeout reached_step5=0 required=1"); end
    checks++;
    if (done !== 1'b1 || done_reason !== 2'b11) begin
      errors++; $display("[TB] FAIL abt_reason actual=%b/%b required=1/11", done, done_reason);
    end
    checks++;
    if (out_valid !== 1'b0 || start_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL abt_drop out_valid/start_ready=%b/%b required=0/0", out_valid, start_ready);
    end
    checks++;
    if (rec_state.size() != 5 || rec_step[rec_step.size()-1] !== 16'd4) begin
      errors++; $display("[TB] FAIL abt_count actual=%0d required=5", rec_state.size());
    end
    tick();
    checks++;
    if (start_ready !== 1'b1) begin errors++; $display("[TB] FAIL abt_idle start_ready=%b required=1", start_ready); end
  endtask

  task automatic test_limit_zero();
    blk_mode  = 0;
    out_ready = 1'b1;
    start_run(8'h10, 8'h00, 8'h00, 16'd0);
    collect(50);
    checks++;
    if (rec_state.size() != 1) begin
      errors++; $display("[TB] FAIL lz_count actual=%0d required=1", rec_state.size());
    end else if (rec_step[0] !== 16'd0 || rec_state[0] !== 8'h10) begin
      errors++; $display("[TB] FAIL lz_rec actual=(%0d,%h) required=(0,10)", rec_step[0], rec_state[0]);
    end
    checks++;
    if (!got_done || done_reason !== 2'b10) begin
      errors++; $display("[TB] FAIL lz_reason actual=%b required=10", done_reason);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    blk_mode  = 0;
    out_ready = 1'b1;
    start_run(8'h40, 8'h00, 8'h00, 16'd5);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rmid_ctrl start_ready/out_valid=%b/%b required=1/0", start_ready, out_valid);
    end
    checks++;
    if (done !== 1'b0 || done_reason !== 2'b00) begin
      errors++; $display("[TB] FAIL rmid_done actual=%b/%b required=0/00", done, done_reason);
    end
    checks++;
    if (logic_cur !== 8'h00 || out_state !== 8'h00 || out_step !== 16'd0) begin
      errors++; $display("[TB] FAIL rmid_data actual=%h/%h/%0d required=00/00/0", logic_cur, out_state, out_step);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_state !== 8'h00) begin
      errors++; $display("[TB] FAIL rmid_hold out_valid/out_state=%b/%h required=0/00", out_valid, out_state);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (start_ready !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rmid_release start_ready/done/out_valid=%b/%b/%b required=1/0/0",
                         start_ready, done, out_valid);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    blk_mode    = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    init_state  = '0;
    force_mask  = '0;
    force_val   = '0;
    max_steps   = '0;
    abort       = 1'b0;
    out_ready   = 1'b1;
    #1;
    test_reset();
    test_counter();
    test_fixed_point();
    test_forced();
    test_stall();
    test_abort();
    test_limit_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
